// File: rtl/m_ucodeseq.sv
// Microcode sequencer: picks the next ROM address from the current microword,
// decoded instruction, branch condition, pending interrupt and memory-wait status.
module m_ucodeseq #(
   parameter logic [7:0]  RESET_ADDR  = 8'h00,
   parameter logic [7:0]  TRAP_ADDR   = 8'h04,
   parameter logic [7:0]  IRQ_ADDR    = 8'h08,
   parameter logic [7:0]  BUSERR_ADDR = 8'h0C,
   parameter int unsigned WAIT_W      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] d,
   input  logic [4:0]  instr_op,
   input  logic [2:0]  instr_f3,
   input  logic        cond,
   input  logic        mem_busy,
   input  logic        irq,
   output logic [7:0]  minx,
   output logic        progress_ucode,
   output logic        trap,
   output logic        buserr
);

   typedef enum logic {BOOT, RUN} state_t;

   typedef enum logic [1:0] {
      SEQ_NEXT     = 2'b00,
      SEQ_JUMP     = 2'b01,
      SEQ_BRANCH   = 2'b10,
      SEQ_DISPATCH = 2'b11
   } seq_op_t;

   typedef struct packed {
      seq_op_t    seq;
      logic [7:0] target;
      logic       wait_mem;
      logic       illegal;
   } uword_t;

   state_t            state, state_nx;
   uword_t            uw;
   logic [7:0]        minx_q;
   logic [WAIT_W-1:0] wcnt;
   logic              irq_pend;
   logic              stall;
   logic              take;
   logic              wcnt_full;
   logic              unused_ok;

   // Only the sequencing fields matter here; the rest belongs to the datapath.
   assign uw        = uword_t'(d[47:36]);
   assign unused_ok = ^d[35:0];
   assign wcnt_full = &wcnt;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         BOOT:    state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   always_comb begin
      minx           = minx_q;
      progress_ucode = 1'b1;
      trap           = 1'b0;
      buserr         = 1'b0;
      stall          = 1'b0;
      take           = 1'b0;
      case (state)
         BOOT: minx = RESET_ADDR;
         RUN: begin
            if (uw.illegal) begin
               minx = TRAP_ADDR;
               trap = 1'b1;
            end else if (uw.wait_mem && mem_busy && !wcnt_full) begin
               // ROM read disabled so d holds and is re-evaluated next cycle
               stall          = 1'b1;
               progress_ucode = 1'b0;
            end else if (uw.wait_mem && mem_busy) begin
               minx   = BUSERR_ADDR;
               buserr = 1'b1;
            end else begin
               case (uw.seq)
                  SEQ_NEXT:   minx = minx_q + 8'd1;
                  SEQ_JUMP:   minx = uw.target;
                  SEQ_BRANCH: minx = cond ? uw.target : minx_q + 8'd1;
                  default: begin
                     if (irq_pend) begin
                        minx = IRQ_ADDR;
                        take = 1'b1;
                     end else begin
                        minx = {instr_op, instr_f3};
                     end
                  end
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         minx_q   <= RESET_ADDR;
         wcnt     <= '0;
         irq_pend <= 1'b0;
      end else begin
         if (progress_ucode) minx_q <= minx;
         wcnt     <= stall ? wcnt + 1'b1 : '0;
         irq_pend <= (irq_pend | irq) & ~take;
      end
   end

endmodule

// File: tb/tb_m_ucodeseq.sv
// Bench for m_ucodeseq: a registered ROM model feeds d, a cycle model predicts
// every output, and directed scenarios pin literal addresses.
module tb_m_ucodeseq;

   logic        clk;
   logic        rst_n;
   logic [47:0] d;
   logic [4:0]  instr_op;
   logic [2:0]  instr_f3;
   logic        cond, mem_busy, irq;
   logic [7:0]  minx;
   logic        progress_ucode, trap, buserr;

   logic [47:0] rom [256];
   int          tests = 0;
   int          fails = 0;

   m_ucodeseq dut (
      .clk(clk), .rst_n(rst_n), .d(d), .instr_op(instr_op), .instr_f3(instr_f3),
      .cond(cond), .mem_busy(mem_busy), .irq(irq), .minx(minx),
      .progress_ucode(progress_ucode), .trap(trap), .buserr(buserr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered ROM: output only updates when the read enable is high.
   initial d = '0;
   always @(posedge clk) if (progress_ucode) d <= rom[minx];

   function automatic logic [47:0] mk(input logic [1:0] s, input logic [7:0] t,
                                      input logic wt, input logic il);
      return {s, t, wt, il, 36'h0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle model: tracks which ROM word is on d, how long it has waited, and
   // whether an interrupt is pending; predicts outputs from the rules directly.
   logic [7:0] m_pc;
   logic       m_boot, m_pend, started;
   int         m_waited;
   logic [7:0] e_minx;
   logic       e_prog, e_trap, e_bus, e_stall, e_take;
   logic [47:0] w;

   initial begin
      m_pc = 8'h00; m_boot = 1'b1; m_pend = 1'b0; m_waited = 0; started = 1'b0;
      forever begin
         @(negedge clk);
         w = rom[m_pc];
         e_prog = 1'b1; e_trap = 1'b0; e_bus = 1'b0; e_stall = 1'b0; e_take = 1'b0;
         e_minx = m_pc;
         if (m_boot) e_minx = 8'h00;
         else if (w[36]) begin e_minx = 8'h04; e_trap = 1'b1; end
         else if (w[37] && mem_busy && m_waited < 15) begin e_stall = 1'b1; e_prog = 1'b0; end
         else if (w[37] && mem_busy) begin e_minx = 8'h0C; e_bus = 1'b1; end
         else begin
            case (w[47:46])
               2'd0: e_minx = m_pc + 8'd1;
               2'd1: e_minx = w[45:38];
               2'd2: e_minx = cond ? w[45:38] : m_pc + 8'd1;
               default: begin
                  if (m_pend) begin e_minx = 8'h08; e_take = 1'b1; end
                  else e_minx = {instr_op, instr_f3};
               end
            endcase
         end
         if (started) begin
            chk("model_minx", {24'h0, minx}, {24'h0, e_minx});
            chk("model_progress", {31'h0, progress_ucode}, {31'h0, e_prog});
            chk("model_trap", {31'h0, trap}, {31'h0, e_trap});
            chk("model_buserr", {31'h0, buserr}, {31'h0, e_bus});
         end
         @(posedge clk);
         if (!rst_n) begin
            m_boot = 1'b1; m_pc = 8'h00; m_waited = 0; m_pend = 1'b0;
         end else begin
            m_boot = 1'b0;
            if (e_prog) m_pc = e_minx;
            m_waited = e_stall ? m_waited + 1 : 0;
            m_pend = (m_pend | irq) & ~e_take;
         end
         started = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset is sampled at one edge; afterwards the block sits in BOOT and the
   // caller may rewrite the ROM before the first fetch.
   task automatic reset_start();
      rst_n = 1'b0;
      step();
      cond = 1'b0; irq = 1'b0; mem_busy = 1'b0; instr_op = 5'h0; instr_f3 = 3'h0;
   endtask

   task automatic release_boot();
      rst_n = 1'b1;
      #1;
      chk("boot_minx", {24'h0, minx}, 32'h00);
      chk("boot_progress", {31'h0, progress_ucode}, 32'h1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rst_n = 1'b0; cond = 1'b0; irq = 1'b0; mem_busy = 1'b0;
      instr_op = 5'h0; instr_f3 = 3'h0;
      step();

      // NEXT then JUMP
      reset_start();
      rom[8'h00] = mk(2'd0, 8'h00, 1'b0, 1'b0);
      rom[8'h01] = mk(2'd1, 8'h40, 1'b0, 1'b0);
      rom[8'h40] = mk(2'd1, 8'h40, 1'b0, 1'b0);
      release_boot();
      step(); #1 chk("next_minx", {24'h0, minx}, 32'h01);
      chk("next_trap", {31'h0, trap | buserr}, 32'h0);
      step(); #1 chk("jump_minx", {24'h0, minx}, 32'h40);

      // NEXT wraps from FF
      reset_start();
      rom[8'h00] = mk(2'd1, 8'hFF, 1'b0, 1'b0);
      rom[8'hFF] = mk(2'd0, 8'h00, 1'b0, 1'b0);
      release_boot();
      step(); #1 chk("jump_ff", {24'h0, minx}, 32'hFF);
      step(); #1 chk("wrap_minx", {24'h0, minx}, 32'h00);

      // BRANCH taken / not taken
      for (int c = 1; c >= 0; c--) begin
         reset_start();
         rom[8'h00] = mk(2'd1, 8'h10, 1'b0, 1'b0);
         rom[8'h10] = mk(2'd2, 8'h20, 1'b0, 1'b0);
         rom[8'h20] = mk(2'd1, 8'h20, 1'b0, 1'b0);
         rom[8'h11] = mk(2'd1, 8'h11, 1'b0, 1'b0);
         cond = c[0];
         release_boot();
         step(); #1 chk("br_pre", {24'h0, minx}, 32'h10);
         step(); #1 chk("branch_minx", {24'h0, minx}, c ? 32'h20 : 32'h11);
      end

      // DISPATCH without interrupt
      reset_start();
      rom[8'h00] = mk(2'd3, 8'h00, 1'b0, 1'b0);
      rom[8'h08] = mk(2'd3, 8'h00, 1'b0, 1'b0);
      rom[8'hC1] = mk(2'd1, 8'hC1, 1'b0, 1'b0);
      instr_op = 5'h18; instr_f3 = 3'b001;
      release_boot();
      step(); #1 chk("dispatch_minx", {24'h0, minx}, 32'hC1);

      // DISPATCH with irq pulsed one cycle earlier, then irq held into the take cycle
      for (int hold = 0; hold < 2; hold++) begin
         reset_start();
         instr_op = 5'h18; instr_f3 = 3'b001;
         irq = 1'b1;
         release_boot();
         step();
         if (hold == 0) irq = 1'b0;
         #1 chk("irq_take", {24'h0, minx}, 32'h08);
         step(); irq = 1'b0;
         #1 chk("irq_cleared", {24'h0, minx}, 32'hC1);
      end

      // Short memory stall
      reset_start();
      rom[8'h00] = mk(2'd1, 8'h30, 1'b0, 1'b0);
      rom[8'h30] = mk(2'd1, 8'h50, 1'b1, 1'b0);
      rom[8'h50] = mk(2'd1, 8'h50, 1'b0, 1'b0);
      rom[8'h0C] = mk(2'd1, 8'h0C, 1'b0, 1'b0);
      rom[8'h04] = mk(2'd1, 8'h04, 1'b0, 1'b0);
      mem_busy = 1'b1;
      release_boot();
      step(); #1 chk("pre_wait", {24'h0, minx}, 32'h30);
      for (int i = 0; i < 3; i++) begin
         step(); #1 chk("stall_prog", {31'h0, progress_ucode}, 32'h0);
         chk("stall_minx", {24'h0, minx}, 32'h30);
      end
      step(); mem_busy = 1'b0;
      #1 chk("resume_minx", {24'h0, minx}, 32'h50);
      chk("resume_prog", {31'h0, progress_ucode}, 32'h1);

      // Timeout after 15 stall cycles
      reset_start();
      mem_busy = 1'b1;
      release_boot();
      step();
      for (int i = 0; i < 15; i++) begin
         step(); #1 chk("to_stall", {31'h0, progress_ucode}, 32'h0);
      end
      step(); #1 chk("buserr_pulse", {31'h0, buserr}, 32'h1);
      chk("buserr_minx", {24'h0, minx}, 32'h0C);
      step(); #1 chk("buserr_drop", {31'h0, buserr}, 32'h0);

      // Illegal beats wait
      reset_start();
      rom[8'h30] = mk(2'd1, 8'h50, 1'b1, 1'b1);
      mem_busy = 1'b1;
      release_boot();
      step();
      step(); #1 chk("trap_minx", {24'h0, minx}, 32'h04);
      chk("trap_pulse", {31'h0, trap}, 32'h1);
      chk("trap_prog", {31'h0, progress_ucode}, 32'h1);
      step(); #1 chk("trap_drop", {31'h0, trap}, 32'h0);

      // Reset mid-stall
      reset_start();
      rom[8'h30] = mk(2'd1, 8'h50, 1'b1, 1'b0);
      mem_busy = 1'b1;
      release_boot();
      step();
      step(); #1 chk("mid_stall", {31'h0, progress_ucode}, 32'h0);
      rst_n = 1'b0;
      step(); #1 chk("rst_stall_minx", {24'h0, minx}, 32'h00);
      chk("rst_stall_prog", {31'h0, progress_ucode}, 32'h1);
      rst_n = 1'b1; mem_busy = 1'b0;
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
